input_conditioner: RTL and testbench

//  Conditions one asynchronous, bouncy input (button/switch/SPI pin) for synchronous logic.
//  - Synchronises the input into the clk domain.
//  - Debounces it: a new level is accepted only after it has been stable for a set time.
//  - Emits one-cycle rising- and falling-edge strobes of the debounced level.

---
 rtl/input_conditioner_pkg.sv | 8 +
 rtl/sync_2ff.sv | 27 ++
 rtl/input_conditioner.sv | 73 +++++++
 tb/tb_input_conditioner.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared defaults for the boundary input conditioner.
// Debounce counter width and stable-cycle wait.
package input_conditioner_pkg;

  localparam int COND_CNT_W = 3;
  localparam int COND_WAIT  = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with synchronous active-high reset.
// Brings one asynchronous bit into the clk domain.
module sync_2ff
  import input_conditioner_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect one noisy input.
// All outputs are driven directly from flops.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int counterwidth = COND_CNT_W,
  parameter int waittime     = COND_WAIT
)
(
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  localparam logic [counterwidth-1:0] WAIT_C =
    counterwidth'(waittime);

  logic                    sync1;
  logic [counterwidth-1:0] cnt_q;
  logic [counterwidth-1:0] cnt_d;
  logic                    cond_q;
  logic                    cond_d;
  logic                    pos_q;
  logic                    pos_d;
  logic                    neg_q;
  logic                    neg_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (noisysignal),
    .q_o   (sync1)
  );

  // Any agreeing cycle restarts the wait, so bounces never accumulate.
  always_comb begin
    cnt_d  = '0;
    cond_d = cond_q;
    pos_d  = 1'b0;
    neg_d  = 1'b0;
    if (sync1 != cond_q) begin
      if (cnt_q == WAIT_C) begin
        cond_d = sync1;
        pos_d  = sync1;
        neg_d  = ~sync1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      cond_q <= 1'b0;
      pos_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cond_q <= cond_d;
      pos_q  <= pos_d;
      neg_q  <= neg_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner.
// Scenario tasks compare the DUT against a sample-history model.
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int W = COND_WAIT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic noisysignal = 1'b0;
  logic conditioned;
  logic positiveedge;
  logic negativeedge;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner dut (
    .clk          (clk),
    .reset        (reset),
    .noisysignal  (noisysignal),
    .conditioned  (conditioned),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge)
  );

  always #10 clk = ~clk;

  // Model: the level seen by the debouncer is the input sampled two
  // edges earlier; it is accepted once it has disagreed with the
  // accepted level on W+1 consecutive edges.
  bit hist[$];
  bit m_cond = 1'b0;
  bit m_pos  = 1'b0;
  bit m_neg  = 1'b0;
  int m_run  = 0;

  always @(posedge clk) begin
    bit s;
    if (reset) begin
      hist.delete();
      m_cond = 1'b0;
      m_pos  = 1'b0;
      m_neg  = 1'b0;
      m_run  = 0;
    end else begin
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      hist.push_back(noisysignal);
      if (hist.size() > 4) void'(hist.pop_front());
      m_pos = 1'b0;
      m_neg = 1'b0;
      if (s != m_cond) begin
        m_run++;
        if (m_run == W + 1) begin
          m_cond = s;
          m_pos  = s;
          m_neg  = !s;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    noisysignal = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (conditioned !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cond: got %b expected 0", conditioned);
    end
    n_checks++;
    if (positiveedge !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_pos: got %b expected 0", positiveedge);
    end
    n_checks++;
    if (negativeedge !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_neg: got %b expected 0", negativeedge);
    end
    noisysignal = 1'b0;
  endtask

  task automatic test_sync();
    logic [2:0] snap;
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 noisysignal = 1'b1;
      #5 noisysignal = 1'b0;
      @(posedge clk);
      #1 snap = {conditioned, positiveedge, negativeedge};
      #2 noisysignal = 1'b1;
      #15 noisysignal = 1'b0;
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !== snap) begin
        n_fail++;
        $display("FAIL sync_between_edges: got %b expected %b",
                 {conditioned, positiveedge, negativeedge}, snap);
      end
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !== 3'b000) begin
        n_fail++;
        $display("FAIL sync_subcycle: got %b expected 000",
                 {conditioned, positiveedge, negativeedge});
      end
    end
  endtask

  task automatic test_debounce(input logic lvl);
    int pulses = 0;
    int wrong  = 0;
    @(negedge clk);
    fork
      begin
        #2 noisysignal = ~lvl;
        #300;
        repeat (10) begin
          #5 noisysignal = ~noisysignal;
        end
        noisysignal = lvl;
        #250;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          n_checks++;
          if ({conditioned, positiveedge, negativeedge} !==
              {m_cond, m_pos, m_neg}) begin
            n_fail++;
            $display("FAIL debounce_model lvl=%b: got %b expected %b",
                     lvl, {conditioned, positiveedge, negativeedge},
                     {m_cond, m_pos, m_neg});
          end
          if (lvl ? positiveedge : negativeedge) pulses++;
          if (lvl ? negativeedge : positiveedge) wrong++;
        end
      end
    join
    n_checks++;
    if (conditioned !== lvl) begin
      n_fail++;
      $display("FAIL debounce_final: got %b expected %b",
               conditioned, lvl);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL debounce_pulses lvl=%b: got %0d expected 1",
               lvl, pulses);
    end
    n_checks++;
    if (wrong != 0) begin
      n_fail++;
      $display("FAIL debounce_wrong_strobe lvl=%b: got %0d expected 0",
               lvl, wrong);
    end
  endtask

  task automatic test_edges();
    for (int p = 0; p < 7; p++) begin
      logic lvl;
      int chg;
      lvl = (p % 2 == 0);
      chg = -1;
      @(negedge clk);
      #2 noisysignal = lvl;
      for (int k = 1; k <= 15; k++) begin
        @(posedge clk);
        #5;
        n_checks++;
        if ({conditioned, positiveedge, negativeedge} !==
            {m_cond, m_pos, m_neg}) begin
          n_fail++;
          $display("FAIL edges_model p=%0d k=%0d: got %b expected %b",
                   p, k, {conditioned, positiveedge, negativeedge},
                   {m_cond, m_pos, m_neg});
        end
        if (chg < 0 && conditioned === lvl) begin
          chg = k;
          n_checks++;
          if ({positiveedge, negativeedge} !== {lvl, ~lvl}) begin
            n_fail++;
            $display("FAIL edges_strobe p=%0d: got %b expected %b",
                     p, {positiveedge, negativeedge}, {lvl, ~lvl});
          end
        end else if (chg > 0 && k == chg + 1) begin
          n_checks++;
          if ({positiveedge, negativeedge} !== 2'b00) begin
            n_fail++;
            $display("FAIL edges_strobe_len p=%0d: got %b expected 00",
                     p, {positiveedge, negativeedge});
          end
        end
      end
      n_checks++;
      if (chg != W + 3) begin
        n_fail++;
        $display("FAIL edges_latency p=%0d: got %0d expected %0d",
                 p, chg, W + 3);
      end
    end
  endtask

  task automatic test_glitch();
    int chg = -1;
    @(negedge clk);
    #2 noisysignal = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      #2 noisysignal = (k == 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #5;
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !==
          {m_cond, m_pos, m_neg}) begin
        n_fail++;
        $display("FAIL glitch_model k=%0d: got %b expected %b",
                 k, {conditioned, positiveedge, negativeedge},
                 {m_cond, m_pos, m_neg});
      end
      if (chg < 0 && conditioned === 1'b1) chg = k;
    end
    n_checks++;
    if (chg != 4 + W + 3) begin
      n_fail++;
      $display("FAIL glitch_latency: got %0d expected %0d",
               chg, 4 + W + 3);
    end
  endtask

  task automatic test_reset_midcount();
    int chg = -1;
    @(negedge clk);
    #2 noisysignal = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    noisysignal = 1'b1;
    @(posedge clk);
    #5;
    n_checks++;
    if ({conditioned, positiveedge, negativeedge} !== 3'b000) begin
      n_fail++;
      $display("FAIL midcount_reset: got %b expected 000",
               {conditioned, positiveedge, negativeedge});
    end
    @(negedge clk);
    #2 reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #5;
      if (chg < 0 && conditioned === 1'b1) begin
        chg = k;
        n_checks++;
        if (positiveedge !== 1'b1) begin
          n_fail++;
          $display("FAIL midcount_pos: got %b expected 1", positiveedge);
        end
      end
    end
    n_checks++;
    if (chg != W + 3) begin
      n_fail++;
      $display("FAIL midcount_latency: got %0d expected %0d",
               chg, W + 3);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        #2 noisysignal = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      @(negedge clk);
      n_checks++;
      if ({conditioned, positiveedge, negativeedge} !==
          {m_cond, m_pos, m_neg}) begin
        n_fail++;
        $display("FAIL random_model i=%0d: got %b expected %b",
                 i, {conditioned, positiveedge, negativeedge},
                 {m_cond, m_pos, m_neg});
      end
      n_checks++;
      if (positiveedge === 1'b1 && negativeedge === 1'b1) begin
        n_fail++;
        $display("FAIL random_both_strobes i=%0d: got 11 expected not 11",
                 i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_debounce(1'b1);
    test_debounce(1'b0);
    test_edges();
    test_glitch();
    test_reset_midcount();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
